// File: rtl/bram_pkg.sv
// Shared types and constants for the byte-enable dual-port memory.
package bram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
  localparam int BYTE_W     = 8;

endpackage

// File: rtl/bram_be_memory_if.sv
// One memory access port. The master owns req/we/be/addr/wdata; the memory returns ready and read results.
interface bram_be_memory_if
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  // A request transfers on any rising edge where req and ready are both 1.
  // There is no further handshake. Reads answer with a one-cycle rvalid pulse,
  // and rdata holds its value until the next read response arrives.
  logic                         req;
  logic                         we;
  logic [DATA_WIDTH/BYTE_W-1:0] be;
  logic [ADDR_WIDTH-1:0]        addr;
  logic [DATA_WIDTH-1:0]        wdata;
  logic                         ready;
  logic                         rvalid;
  logic [DATA_WIDTH-1:0]        rdata;
  logic                         err;

  modport master (
    output req, we, be, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ready, rvalid, rdata, err
  );

endinterface

// File: rtl/bram_rd_pipe.sv
// Read-response delay line: carries valid/err/data through LAT register stages.
module bram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LAT        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [LAT-1:0]        v_q;
  logic [LAT-1:0]        e_q;
  logic [DATA_WIDTH-1:0] d_q [LAT];

  // Data stages only load on a valid beat, so the last stage holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      e_q <= '0;
      for (int i = 0; i < LAT; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= in_valid;
      e_q[0] <= in_valid & in_err;
      if (in_valid) d_q[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        e_q[i] <= e_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign out_err   = e_q[LAT-1];
  assign out_data  = d_q[LAT-1];

endmodule

// File: rtl/bram_be_memory.sv
// Dual-port byte-enable memory with read-first ordering and A-priority on write collisions.
// Define BRAM_RESET_CLEAR_EN to zero the whole array after every reset release.
module bram_be_memory
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 200,
  parameter int RD_LATENCY = 1
) (
  input  logic              m_clk,
  input  logic              M_rst,
  bram_be_memory_if.slave   a,
  bram_be_memory_if.slave   b,
  output logic              wr_collision,
  output logic              init_busy,
  output state_e            dbg_state
);

  localparam int BW    = DATA_WIDTH / BYTE_W;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LAT   = (RD_LATENCY >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_e           state;
  logic [IDX_W-1:0] clr_addr;
  logic             busy_q;
  logic             clr_en;

`ifdef BRAM_RESET_CLEAR_EN
  always_ff @(posedge m_clk) begin
    if (M_rst) begin
      state    <= INIT;
      clr_addr <= '0;
      busy_q   <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          if (clr_addr == IDX_W'(MEM_DEPTH - 1)) begin
            state  <= RUN;
            busy_q <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: busy_q <= 1'b0;
      endcase
    end
  end
  assign clr_en = (state == INIT) && !M_rst;
`else
  assign state    = RUN;
  assign clr_addr = '0;
  assign busy_q   = 1'b0;
  assign clr_en   = 1'b0;
`endif

  assign init_busy = busy_q;
  assign dbg_state = state;
  assign a.ready   = !busy_q;
  assign b.ready   = !busy_q;

  // Requests arriving while reset is held are dropped rather than accepted.
  logic a_acc, b_acc, a_wr, b_wr, a_rd, b_rd, a_in, b_in;
  logic [IDX_W-1:0] a_idx, b_idx;

  assign a_acc = a.req && a.ready && !M_rst;
  assign b_acc = b.req && b.ready && !M_rst;
  assign a_wr  = a_acc && a.we;
  assign b_wr  = b_acc && b.we;
  assign a_rd  = a_acc && !a.we;
  assign b_rd  = b_acc && !b.we;
  assign a_in  = a.addr < ADDR_WIDTH'(MEM_DEPTH);
  assign b_in  = b.addr < ADDR_WIDTH'(MEM_DEPTH);
  assign a_idx = a.addr[IDX_W-1:0];
  assign b_idx = b.addr[IDX_W-1:0];

  logic [DATA_WIDTH-1:0] a_rd_data, b_rd_data;
  always_comb begin
    a_rd_data = '0;
    b_rd_data = '0;
    if (a_in) a_rd_data = mem[a_idx];
    if (b_in) b_rd_data = mem[b_idx];
  end

  // B is applied before A so A's bytes take precedence where enables overlap;
  // reads sample the pre-write contents, giving read-first behaviour.
  always_ff @(posedge m_clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int i = 0; i < BW; i++)
        if (b_wr && b_in && b.be[i]) mem[b_idx][i*BYTE_W +: BYTE_W] <= b.wdata[i*BYTE_W +: BYTE_W];
      for (int i = 0; i < BW; i++)
        if (a_wr && a_in && a.be[i]) mem[a_idx][i*BYTE_W +: BYTE_W] <= a.wdata[i*BYTE_W +: BYTE_W];
    end
  end

  logic a_werr_q, b_werr_q, coll_q;
  always_ff @(posedge m_clk) begin
    if (M_rst) begin
      a_werr_q <= 1'b0;
      b_werr_q <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      a_werr_q <= a_wr && !a_in;
      b_werr_q <= b_wr && !b_in;
      coll_q   <= a_wr && b_wr && (a.addr == b.addr);
    end
  end
  assign wr_collision = coll_q;

  logic a_rerr, b_rerr;

  bram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LAT(LAT)) u_rd_pipe_a (
    .clk      (m_clk),
    .rst      (M_rst),
    .in_valid (a_rd),
    .in_err   (!a_in),
    .in_data  (a_rd_data),
    .out_valid(a.rvalid),
    .out_err  (a_rerr),
    .out_data (a.rdata)
  );

  bram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LAT(LAT)) u_rd_pipe_b (
    .clk      (m_clk),
    .rst      (M_rst),
    .in_valid (b_rd),
    .in_err   (!b_in),
    .in_data  (b_rd_data),
    .out_valid(b.rvalid),
    .out_err  (b_rerr),
    .out_data (b.rdata)
  );

  assign a.err = a_rerr | a_werr_q;
  assign b.err = b_rerr | b_werr_q;

endmodule

// File: tb/tb_bram_be_memory.sv
// Directed bench for bram_be_memory: byte enables, collisions, read-first, range errors, reset.
module tb_bram_be_memory;
  import bram_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 200;
  localparam int LAT   = 1;

  logic   m_clk;
  logic   M_rst;
  logic   wr_collision;
  logic   init_busy;
  state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  bram_be_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a_if ();
  bram_be_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_if ();

  bram_be_memory #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .RD_LATENCY(LAT)
  ) dut (
    .m_clk       (m_clk),
    .M_rst       (M_rst),
    .a           (a_if.slave),
    .b           (b_if.slave),
    .wr_collision(wr_collision),
    .init_busy   (init_busy),
    .dbg_state   (dbg_state)
  );

  // Clock / watchdog
  initial m_clk = 1'b0;
  always #5 m_clk = ~m_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Checker
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic tick;
    @(posedge m_clk);
    #1;
  endtask

  task automatic clr_req;
    a_if.req = 1'b0;
    b_if.req = 1'b0;
  endtask

  task automatic a_set(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    a_if.req = 1'b1; a_if.we = we; a_if.be = be; a_if.addr = addr; a_if.wdata = wd;
  endtask

  task automatic b_set(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    b_if.req = 1'b1; b_if.we = we; b_if.be = be; b_if.addr = addr; b_if.wdata = wd;
  endtask

  task automatic wr_a(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    a_set(1'b1, be, addr, wd);
    tick;
    clr_req;
  endtask

  // Issue a read on one port and sample its response LAT cycles after acceptance.
  task automatic rd(input bit on_b, input logic [31:0] addr,
                    output logic [31:0] data, output logic vld, output logic err);
    if (on_b) b_set(1'b0, 4'h0, addr, 32'h0);
    else      a_set(1'b0, 4'h0, addr, 32'h0);
    tick;
    clr_req;
    repeat (LAT - 1) tick;
    data = on_b ? b_if.rdata  : a_if.rdata;
    vld  = on_b ? b_if.rvalid : a_if.rvalid;
    err  = on_b ? b_if.err    : a_if.err;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!a_if.ready && n < 1000) begin
      tick;
      n++;
    end
  endtask

  logic [31:0] d;
  logic        v, e;
  int          n, bad;

  initial begin
    M_rst = 1'b1;
    a_if.req = 1'b0; a_if.we = 1'b0; a_if.be = '0; a_if.addr = '0; a_if.wdata = '0;
    b_if.req = 1'b0; b_if.we = 1'b0; b_if.be = '0; b_if.addr = '0; b_if.wdata = '0;
    repeat (3) tick;
    check("rst_a_rvalid", a_if.rvalid, 1'b0);
    check("rst_b_rdata",  b_if.rdata,  32'h0);
    check("rst_a_err",    a_if.err,    1'b0);
    check("rst_coll",     wr_collision, 1'b0);
    M_rst = 1'b0;
`ifdef BRAM_RESET_CLEAR_EN
    check("init_busy_start", init_busy, 1'b1);
    wait_ready(n);
    check("init_len", n, DEPTH);
`else
    check("ready_first", a_if.ready, 1'b1);
    check("init_busy_off", init_busy, 1'b0);
`endif

    // Full-word write on A, read back on B
    wr_a(32'd5, 32'hDEADBEEF, 4'hF);
    check("wr5_err", a_if.err, 1'b0);
    rd(1'b1, 32'd5, d, v, e);
    check("rd5_valid", v, 1'b1);
    check("rd5_data", d, 32'hDEADBEEF);
    check("rd5_err", e, 1'b0);
    tick;
    check("rd5_pulse", b_if.rvalid, 1'b0);
    check("rd5_hold", b_if.rdata, 32'hDEADBEEF);

    // Byte enables, including an all-zero enable
    wr_a(32'd7, 32'h11223344, 4'hF);
    wr_a(32'd7, 32'hAABBCCDD, 4'b0101);
    wr_a(32'd7, 32'hFFFFFFFF, 4'b0000);
    rd(1'b0, 32'd7, d, v, e);
    check("be_merge", d, 32'h11BB33DD);

    // Back-to-back reads, one response per cycle
    wr_a(32'd10, 32'hA0A0A0A0, 4'hF);
    wr_a(32'd11, 32'hB1B1B1B1, 4'hF);
    wr_a(32'd12, 32'hC2C2C2C2, 4'hF);
    a_set(1'b0, 4'h0, 32'd10, 32'h0); tick;
    check("burst0", a_if.rdata, 32'hA0A0A0A0);
    a_set(1'b0, 4'h0, 32'd11, 32'h0); tick;
    check("burst1_v", a_if.rvalid, 1'b1);
    check("burst1", a_if.rdata, 32'hB1B1B1B1);
    a_set(1'b0, 4'h0, 32'd12, 32'h0); tick;
    check("burst2", a_if.rdata, 32'hC2C2C2C2);
    clr_req; tick;
    check("burst_end", a_if.rvalid, 1'b0);

    // Same-address write collision, full overlap
    a_set(1'b1, 4'hF, 32'd3, 32'hFFFFFFFF);
    b_set(1'b1, 4'hF, 32'd3, 32'h00000000);
    tick; clr_req;
    check("coll_pulse", wr_collision, 1'b1);
    tick;
    check("coll_drop", wr_collision, 1'b0);
    rd(1'b0, 32'd3, d, v, e);
    check("coll_a_wins", d, 32'hFFFFFFFF);

    // Partial overlap: A wins byte 1, B keeps byte 2
    wr_a(32'd4, 32'h0, 4'hF);
    a_set(1'b1, 4'b0011, 32'd4, 32'h11111111);
    b_set(1'b1, 4'b0110, 32'd4, 32'h22222222);
    tick; clr_req;
    check("coll2_pulse", wr_collision, 1'b1);
    rd(1'b1, 32'd4, d, v, e);
    check("coll2_merge", d, 32'h00221111);

    // Different addresses in the same cycle are not a collision
    a_set(1'b1, 4'hF, 32'd20, 32'h20202020);
    b_set(1'b1, 4'hF, 32'd21, 32'h21212121);
    tick; clr_req;
    check("nocoll", wr_collision, 1'b0);
    rd(1'b0, 32'd21, d, v, e);
    check("nocoll_b_data", d, 32'h21212121);

    // Read-first against an opposite-port write
    wr_a(32'd9, 32'h1, 4'hF);
    a_set(1'b0, 4'h0, 32'd9, 32'h0);
    b_set(1'b1, 4'hF, 32'd9, 32'h2);
    tick; clr_req;
    check("rf_valid", a_if.rvalid, 1'b1);
    check("rf_old", a_if.rdata, 32'h1);
    rd(1'b0, 32'd9, d, v, e);
    check("rf_new", d, 32'h2);

    // Address range boundary
    wr_a(32'd199, 32'h19919919, 4'hF);
    check("last_wr_err", a_if.err, 1'b0);
    rd(1'b0, 32'd199, d, v, e);
    check("last_rd", d, 32'h19919919);
    check("last_rd_err", e, 1'b0);
    rd(1'b0, 32'd200, d, v, e);
    check("oor_rd_valid", v, 1'b1);
    check("oor_rd_err", e, 1'b1);
    check("oor_rd_data", d, 32'h0);
    b_set(1'b1, 4'hF, 32'd250, 32'h12345678);
    tick; clr_req;
    check("oor_wr_err", b_if.err, 1'b1);
    tick;
    check("oor_wr_err_drop", b_if.err, 1'b0);
    rd(1'b0, 32'd5, d, v, e);
    check("oor_no_corrupt", d, 32'hDEADBEEF);

    // Reset while a read burst is being issued
    a_set(1'b0, 4'h0, 32'd10, 32'h0); tick;
    check("pre_rst_rd", a_if.rvalid, 1'b1);
    M_rst = 1'b1;
    a_set(1'b0, 4'h0, 32'd11, 32'h0); tick;
    check("rst_drop_v", a_if.rvalid, 1'b0);
    check("rst_drop_d", a_if.rdata, 32'h0);
    tick;
    check("rst_drop_v2", a_if.rvalid, 1'b0);
    clr_req;
    M_rst = 1'b0;
`ifdef BRAM_RESET_CLEAR_EN
    check("reinit_busy", init_busy, 1'b1);
    check("reinit_state", dbg_state, INIT);
    wait_ready(n);
    check("reinit_len", n, DEPTH);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rd(1'b0, i, d, v, e);
      if (d !== 32'h0 || v !== 1'b1) bad++;
    end
    check("cleared_words_bad", bad, 0);
`else
    check("rel_ready", a_if.ready, 1'b1);
    check("rel_state", dbg_state, RUN);
    rd(1'b0, 32'd5, d, v, e);
    check("retained", d, 32'hDEADBEEF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
